// File: rtl/proj_pkg.sv
// Shared types and constants for the perspective-divide stage:
// Q16.16 words, clip-space vertex, screen vertex, FSM states.
package proj_pkg;

    localparam int FRAC = 16;
    localparam int QW   = 32 + FRAC;
    localparam logic signed [31:0] Q_ONE = 32'sh0001_0000;

    typedef logic signed [31:0] q16_t;
    typedef q16_t [3:0] vertex_t;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
    } scr_vtx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_MAP,
        S_OUT
    } state_t;

    // Apply the quotient sign and clip the magnitude to the Q16.16 range.
    function automatic q16_t sat_q16(input logic neg, input logic [QW-1:0] mag);
        q16_t r;
        if (!neg)
            r = (mag > QW'(32'h7FFF_FFFF)) ? 32'sh7FFF_FFFF : q16_t'(mag[31:0]);
        else
            r = (mag > QW'(32'h8000_0000)) ? 32'sh8000_0000 : q16_t'(-mag[31:0]);
        return r;
    endfunction

endpackage

// File: rtl/persp_divide_if.sv
// Triangle-in / screen-triangle-out handshake bundle.
// master = upstream/downstream environment, slave = the divide block.
interface persp_divide_if;
    import proj_pkg::*;

    vertex_t  [2:0] homo_tri;
    logic           tri_valid_in;
    logic           tri_ready_out;
    scr_vtx_t [2:0] triangle;
    logic           culled_out;
    logic           valid_out;
    logic           ready_in;

    modport master (
        output homo_tri, tri_valid_in, ready_in,
        input  tri_ready_out, triangle, culled_out, valid_out
    );

    modport slave (
        input  homo_tri, tri_valid_in, ready_in,
        output tri_ready_out, triangle, culled_out, valid_out
    );

endinterface

// File: rtl/fxp_div_serial.sv
// Signed Q16.16 restoring divider, one quotient bit per cycle (QW cycles).
// den is assumed positive; the first bit is resolved on the start cycle itself.
module fxp_div_serial
    import proj_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic start,
    input  q16_t num,
    input  q16_t den,
    output logic busy,
    output logic done,
    output q16_t quo
);

    logic [5:0]    r_cnt;
    logic [31:0]   r_rem;
    logic [QW-1:0] r_dvd;
    logic [QW-1:0] r_q;
    logic          r_neg;

    logic [31:0]   w_mag;
    logic [31:0]   w_rem_src;
    logic [31:0]   w_rem_nxt;
    logic [QW-1:0] w_dvd_src;
    logic [QW-1:0] w_q_src;
    logic [QW-1:0] w_q_nxt;
    logic [32:0]   w_trial;
    logic [32:0]   w_diff;
    logic          w_ge;
    logic          w_unused;

    assign w_mag     = num[31] ? 32'(-num) : 32'(num);

    // On start the fresh operands feed the step directly, saving a load cycle.
    assign w_rem_src = start ? '0 : r_rem;
    assign w_dvd_src = start ? {w_mag, {FRAC{1'b0}}} : r_dvd;
    assign w_q_src   = start ? '0 : r_q;

    assign w_trial   = {w_rem_src, w_dvd_src[QW-1]};
    assign w_ge      = w_trial >= {1'b0, den};
    assign w_diff    = w_trial - {1'b0, den};
    assign w_rem_nxt = w_ge ? w_diff[31:0] : w_trial[31:0];
    assign w_q_nxt   = {w_q_src[QW-2:0], w_ge};
    assign w_unused  = w_diff[32];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= '0;
            r_q   <= '0;
            r_neg <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                r_rem <= w_rem_nxt;
                r_dvd <= {w_dvd_src[QW-2:0], 1'b0};
                r_q   <= w_q_nxt;
            end
            if (start) begin
                r_neg <= num[31];
                r_cnt <= 6'(QW - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                r_cnt <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    quo  <= sat_q16(r_neg, w_q_nxt);
                end
            end
        end
    end

endmodule

// File: rtl/persp_divide.sv
// Clip-space triangle -> screen-pixel triangle: per-vertex x/w, y/w,
// viewport map with clamping, cull on w <= 0, valid/ready output.
module persp_divide
    import proj_pkg::*;
#(
    parameter int H_RES = 1024,
    parameter int V_RES = 768
)
(
    input  logic           clk_in,
    input  logic           rst_in,
    persp_divide_if.slave  bus
);

    localparam int NUM_LANES = 2;  // lane 0 divides x, lane 1 divides y
    localparam logic signed [47:0] HALF_H = 48'(H_RES / 2);
    localparam logic signed [47:0] HALF_V = 48'(V_RES / 2);
    localparam logic signed [47:0] X_MAX  = 48'(H_RES - 1);
    localparam logic signed [47:0] Y_MAX  = 48'(V_RES - 1);
    localparam logic signed [33:0] ONE34  = 34'(Q_ONE);

    state_t         r_state;
    state_t         w_state_nxt;
    vertex_t  [2:0] r_vtx;
    logic     [1:0] r_v;
    logic           r_cull;
    logic           r_vcull;
    scr_vtx_t [2:0] r_tri;
    scr_vtx_t [2:0] r_tri_out;
    logic           r_culled_out;
    logic           r_valid;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_w_pos;
    q16_t                  w_w;
    q16_t [NUM_LANES-1:0]  w_num;
    q16_t [NUM_LANES-1:0]  w_quo;
    logic [NUM_LANES-1:0]  w_busy;
    logic [NUM_LANES-1:0]  w_done;
    logic                  w_unused;

    logic signed [33:0] w_sum_x, w_sum_y;
    logic signed [47:0] w_px, w_py, w_sx, w_sy;
    logic        [15:0] w_sx_c, w_sy_c;

    assign w_w      = r_vtx[r_v][3];
    assign w_num[0] = r_vtx[r_v][0];
    assign w_num[1] = r_vtx[r_v][1];
    assign w_w_pos  = !w_w[31] && (w_w != '0);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        fxp_div_serial u_div (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .start  (w_start),
            .num    (w_num[g]),
            .den    (w_w),
            .busy   (w_busy[g]),
            .done   (w_done[g]),
            .quo    (w_quo[g])
        );
    end

    // Viewport map; 34-bit sums keep a saturated NDC of +/-32768.0 from wrapping.
    assign w_sum_x = 34'($signed(w_quo[0])) + ONE34;
    assign w_sum_y = ONE34 - 34'($signed(w_quo[1]));
    assign w_px    = 48'(w_sum_x) * HALF_H;
    assign w_py    = 48'(w_sum_y) * HALF_V;
    assign w_sx    = w_px >>> FRAC;
    assign w_sy    = w_py >>> FRAC;

    assign w_sx_c = (w_sx < 48'sd0) ? 16'd0 : (w_sx > X_MAX) ? 16'(X_MAX) : w_sx[15:0];
    assign w_sy_c = (w_sy < 48'sd0) ? 16'd0 : (w_sy > Y_MAX) ? 16'(Y_MAX) : w_sy[15:0];

    assign w_unused = ^{w_busy, r_vtx[0][2], r_vtx[1][2], r_vtx[2][2]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: if (bus.tri_valid_in) begin
                w_accept    = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: if (w_w_pos) begin
                w_start     = 1'b1;
                w_state_nxt = S_DIV;
            end else begin
                w_state_nxt = S_MAP;
            end
            S_DIV:  if (&w_done) w_state_nxt = S_MAP;
            S_MAP:  w_state_nxt = (r_v == 2'd2) ? S_OUT : S_LOAD;
            S_OUT:  if (r_valid && bus.ready_in) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_vtx        <= '0;
            r_v          <= '0;
            r_cull       <= 1'b0;
            r_vcull      <= 1'b0;
            r_tri        <= '0;
            r_tri_out    <= '0;
            r_culled_out <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_vtx  <= bus.homo_tri;
                    r_v    <= 2'd0;
                    r_cull <= 1'b0;
                end
                S_LOAD: begin
                    r_vcull <= !w_w_pos;
                    r_cull  <= r_cull | !w_w_pos;
                end
                S_MAP: begin
                    r_tri[r_v] <= r_vcull ? '0 : {w_sy_c, w_sx_c};
                    if (r_v != 2'd2) r_v <= r_v + 2'd1;
                end
                // First OUT cycle publishes the triangle, zeroed when any vertex culled.
                S_OUT: if (!r_valid) begin
                    r_valid      <= 1'b1;
                    r_tri_out    <= r_cull ? '0 : r_tri;
                    r_culled_out <= r_cull;
                end else if (bus.ready_in) begin
                    r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.tri_ready_out = (r_state == S_IDLE);
    assign bus.triangle      = r_tri_out;
    assign bus.culled_out    = r_culled_out;
    assign bus.valid_out     = r_valid;

endmodule
